// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester request/grant bundle plus register-bank write port.
interface reg_write_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic                     en;
  logic [NREQ-1:0]          req;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*WIDTH-1:0]    req_data;
  logic [NREQ-1:0]          gnt;
  logic                     we;
  logic [ADDR_W-1:0]        we_addr;
  logic [WIDTH-1:0]         we_data;
  logic                     busy;
  modport master (output en, req, req_addr, req_data, input gnt, we, we_addr, we_data, busy);
  modport slave  (input en, req, req_addr, req_data, output gnt, we, we_addr, we_data, busy);
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin, burst-bounded arbiter for the register-bank write port.
module reg_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              nreset,
  reg_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, nxt, w;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               we_q, cont, grant;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  // Scan downwards so the last hit is the one closest to p in rotation order.
  function automatic logic [PW-1:0] pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] s;
    s = p;
    for (int k = NREQ - 1; k >= 0; k--)
      if (r[(int'(p) + k) % NREQ]) s = PW'((int'(p) + k) % NREQ);
    return s;
  endfunction
  always_comb begin
    cont    = state_q == SERVE && bus.en && bus.req[owner_q] && cnt_q < CW'(MAX_BURST);
    nxt     = owner_q == PW'(NREQ - 1) ? '0 : owner_q + 1'b1;
    ptr_d   = (state_q == SERVE && !cont) ? nxt : ptr_q;
    grant   = cont || (bus.en && |bus.req);
    w       = cont ? owner_q : pick(bus.req, ptr_d);
    owner_d = grant ? w : owner_q;
    cnt_d   = cont ? cnt_q + 1'b1 : (grant ? CW'(1) : '0);
    gnt_d   = grant ? {{(NREQ-1){1'b0}}, 1'b1} << w : '0;
    addr_d  = grant ? bus.req_addr[w*ADDR_W +: ADDR_W] : addr_q;
    data_d  = grant ? bus.req_data[w*WIDTH +: WIDTH] : data_q;
    state_d = grant ? SERVE : IDLE;
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= grant;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  assign bus.gnt     = gnt_q;
  assign bus.we      = we_q;
  assign bus.we_addr = addr_q;
  assign bus.we_data = data_q;
  assign bus.busy    = state_q == SERVE;
  a_params: assert property (@(posedge clk) NREQ >= 2 && NREQ <= 8 && MAX_BURST >= 1 && MAX_BURST <= 15);
  a_gnt: assert property (@(posedge clk) disable iff (!nreset) $onehot0(gnt_q) && (we_q == (gnt_q != '0)));
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenario tasks with hand-computed grant sequences.
module tb_reg_write_arbiter;
  logic clk, nreset;
  int checks, errors;
  reg_write_arbiter_if #(.NREQ(4), .WIDTH(8), .ADDR_W(3)) bus ();
  reg_write_arbiter #(.NREQ(4), .WIDTH(8), .ADDR_W(3), .MAX_BURST(4)) dut (
    .clk(clk), .nreset(nreset), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    nreset = 0;
    bus.en = 1;
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*3 +: 3] = 3'(i);
      bus.req_data[i*8 +: 8] = 8'hC0 + 8'(i);
    end
    tick();
    nreset = 1;
  endtask
  task automatic test_reset;
    nreset = 0;
    bus.en = 1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    #2;
    checks++;
    if ({bus.gnt, bus.we, bus.we_addr, bus.we_data, bus.busy} !== 17'd0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b we=%b addr=%0d data=%h busy=%b exp all zero", bus.gnt, bus.we, bus.we_addr, bus.we_data, bus.busy);
    end
  endtask
  task automatic test_reset_mid_burst;
    do_reset();
    bus.req = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.we !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset_burst[%0d] got gnt=%b we=%b exp gnt=0001 we=1", k, bus.gnt, bus.we);
      end
    end
    #3;
    nreset = 0;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.we !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got gnt=%b we=%b busy=%b exp 0000 0 0", bus.gnt, bus.we, bus.busy);
    end
    bus.req = 4'b0010;
    #2;
    nreset = 1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.we !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant got gnt=%b we=%b exp gnt=0010 we=1", bus.gnt, bus.we);
    end
  endtask
  task automatic test_single;
    do_reset();
    bus.req = 4'b0100;
    bus.req_addr[6 +: 3] = 3'd5;
    bus.req_data[16 +: 8] = 8'hA5;
    tick();
    checks++;
    if ({bus.we, bus.gnt, bus.we_addr, bus.we_data, bus.busy} !== {1'b1, 4'b0100, 3'd5, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_capture got we=%b gnt=%b addr=%0d data=%h busy=%b exp 1 0100 5 a5 1", bus.we, bus.gnt, bus.we_addr, bus.we_data, bus.busy);
    end
    bus.req = 4'b0000;
    bus.req_data[16 +: 8] = 8'h3C;
    tick();
    checks++;
    if ({bus.we, bus.gnt, bus.busy} !== 6'd0) begin
      errors++;
      $display("FAIL single_drop got we=%b gnt=%b busy=%b exp 0 0000 0", bus.we, bus.gnt, bus.busy);
    end
    checks++;
    if (bus.we_addr !== 3'd5 || bus.we_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold got addr=%0d data=%h exp 5 a5", bus.we_addr, bus.we_data);
    end
  endtask
  task automatic test_burst_rotation;
    logic [3:0] exp_g [12] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1};
    do_reset();
    bus.req = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (bus.gnt !== exp_g[k] || bus.we !== 1'b1) begin
        errors++;
        $display("FAIL burst[%0d] got gnt=%b we=%b exp gnt=%b we=1", k, bus.gnt, bus.we, exp_g[k]);
      end
    end
  endtask
  task automatic test_sole_regrant;
    do_reset();
    bus.req = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b1000 || bus.we !== 1'b1 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL sole[%0d] got gnt=%b we=%b busy=%b exp 1000 1 1", k, bus.gnt, bus.we, bus.busy);
      end
    end
  endtask
  task automatic test_fairness;
    int exp_o [15] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};
    logic [3:0] eg;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      tick();
      eg = 4'b0001 << exp_o[k];
      checks++;
      if (bus.gnt !== eg || bus.we_addr !== 3'(exp_o[k]) || bus.we_data !== 8'hC0 + 8'(exp_o[k])) begin
        errors++;
        $display("FAIL fair[%0d] got gnt=%b addr=%0d data=%h exp gnt=%b addr=%0d data=%h", k, bus.gnt, bus.we_addr, bus.we_data, eg, exp_o[k], 8'hC0 + 8'(exp_o[k]));
      end
      if (k == 1) bus.req = 4'b1110;
    end
  endtask
  task automatic test_en_gating;
    do_reset();
    bus.req = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0010) begin
        errors++;
        $display("FAIL en_pre[%0d] got gnt=%b exp 0010", k, bus.gnt);
      end
    end
    bus.en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.we, bus.gnt, bus.busy} !== 6'd0) begin
        errors++;
        $display("FAIL en_low[%0d] got we=%b gnt=%b busy=%b exp 0 0000 0", k, bus.we, bus.gnt, bus.busy);
      end
    end
    bus.en = 1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.we !== 1'b1) begin
      errors++;
      $display("FAIL en_resume got gnt=%b we=%b exp gnt=0100 we=1", bus.gnt, bus.we);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_burst();
    test_single();
    test_burst_rotation();
    test_sole_regrant();
    test_fairness();
    test_en_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the team's D-flip-flop register bank among NREQ requesters.
- Each requester presents a request, an address and data. The arbiter captures the winner's address and data, drives a registered write strobe into the bank, and returns a one-hot grant as the capture acknowledgement.
- Bounded bursts stop any one requester from starving the others.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width per requester
- ADDR_W, 3, register-bank address width
- MAX_BURST, 4, maximum consecutive writes granted to one owner before forced rotation (1..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- nreset  input  1  asynchronous, active-low reset
- en  input  1  arbitration enable; low blocks new grants
- req  input  NREQ  per-requester write request, level
- req_addr  input  NREQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  NREQ*WIDTH  flattened data; requester i at bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot, registered; gnt[i]=1 means requester i's addr/data were captured at the previous edge
- we  output  1  registered write strobe to the register bank
- we_addr  output  ADDR_W  registered write address
- we_data  output  WIDTH  registered write data
- busy  output  1  high while state is SERVE

Behaviour:
- Reset (nreset=0, asynchronous, takes effect immediately, including mid-burst):
  - gnt=0, we=0, we_addr=0, we_data=0, busy=0
  - state=IDLE, ptr=0, owner=0, cnt=0
- Decision rule (both states):
  - All decisions are made on the rising edge from the current req/en values.
  - Outputs are registered. Latency from a req sampled at edge N to we/gnt high is one cycle (visible after edge N).
- Round-robin pick from pointer p: the first i in order p, p+1, ..., NREQ-1, 0, ..., p-1 with req[i]=1.
- State IDLE, at an edge:
  - en=0 or req=0: stay IDLE; we=0, gnt=0.
  - Otherwise: winner w = pick(ptr); owner=w; cnt=1; capture req_addr[w] and req_data[w]; we=1; gnt=onehot(w); go to SERVE.
- State SERVE, at an edge:
  - Continue: en=1 AND req[owner]=1 AND cnt<MAX_BURST. Owner keeps the port; cnt=cnt+1; capture owner's addr/data; we=1; gnt=onehot(owner).
  - Rotate: otherwise set ptr=(owner+1) mod NREQ in the same edge.
    - If en=1 and any req: w = pick(new ptr), with no idle bubble. owner=w; cnt=1; capture; we=1; gnt=onehot(w); stay in SERVE.
    - Else: we=0, gnt=0, go to IDLE.
  - The former owner may win again after rotation if it is the only requester; this starts a fresh burst with cnt=1.
- Handshake (requester side):
  - Hold req, addr and data stable until gnt[i] is seen high.
  - In the gnt[i] cycle, either present the next word (req stays high) or drop req.
  - Deasserting req before grant withdraws the request; no write occurs.
- Invariants:
  - we=1 exactly when gnt≠0.
  - gnt is always one-hot or zero.
  - we_addr/we_data hold their last captured values while we=0.
- en low mid-burst: the next edge ends the burst (rotation rule, no new grant); state goes to IDLE and ptr advances past the owner.
- Counter: cnt is a $clog2(MAX_BURST+1)-bit counter and never exceeds MAX_BURST. With MAX_BURST=1 every write rotates.
- Pointer wrap: owner=NREQ-1 rotates ptr to 0.
- Out-of-range NREQ/MAX_BURST values are unsupported; assertion only, no RTL handling.

Test Plan:
- Reset mid-burst:
  - Stimulus: req=0001 for 2 cycles, then nreset=0 asynchronously between edges.
  - Response: gnt=0000, we=0, busy=0 immediately, before the next edge.
  - After release with req=0010: first grant goes to gnt=0010 (ptr=0 scan).
- Single requester, data capture:
  - Stimulus: req=0100, req_addr[2]=5, data[2]=0xA5.
  - Response: one cycle later we=1, gnt=0100, we_addr=5, we_data=0xA5.
  - Drop req in the grant cycle → next cycle we=0, IDLE.
- Burst limit and rotation:
  - Stimulus: req=0011 held constantly, MAX_BURST=4.
  - Response: gnt=0001 for 4 consecutive cycles, then 0010 for 4, then 0001, with no idle bubble between.
- Sole requester re-grant:
  - Stimulus: req=1000 held for 10 cycles.
  - Response: gnt=1000 on all 10 cycles; cnt goes 1..4, 1..4, 1..2; ptr wraps to 0 at each rotation.
- Fairness after early drop:
  - Stimulus: req=1111; requester 0 drops req after its 2nd grant.
  - Response: grant order 0,0,1,1,1,1,2,2,2,2,3,3,3,3, then 1 (requester 0 absent).
- en gating:
  - Stimulus: req=0110 granted to 1 (cnt=2); en=0 for 3 cycles; then en=1.
  - Response: we=0/gnt=0 during en=0, state IDLE; on resume, first grant is gnt=0100 (ptr advanced to 2).
